cpu_core: RTL and testbench
===========================

CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, register/ALU/bus width (legal 8..32).
REQ-002 SHALL provide parameter PC_W, default 8, program counter and instruction address width (legal 4..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port inst_req  output  1  fetch request; high only in FETCH state.
REQ-006 SHALL have port inst_addr  output  PC_W  fetch address; equals pc.
REQ-007 SHALL have port inst_valid  input  1  instruction memory response valid.
REQ-008 SHALL have port inst_data  input  8  instruction word; sampled only when inst_req and inst_valid are both high.
REQ-009 SHALL have port halted  output  1  high in HALT state.
REQ-010 SHALL have port retire  output  1  one-cycle pulse in the final cycle of every instruction.
REQ-011 SHALL have port r0_out  output  DATA_W  current value of accumulator R0.
REQ-012 SHALL have ports zero_flag, carry_flag  output  1 each  ALU flags.

Function
REQ-013 SHALL hold 8 general registers R0..R7 of DATA_W bits, plus RA and RC of DATA_W bits, pc, and an 8-bit IR.
REQ-014 SHALL decode IR as op = IR[7:6], f1 = IR[5:3], f2 = IR[2:0].
REQ-015 SHALL implement states FETCH, EXEC, LOADA, ALU, WB, HALT.
REQ-016 In FETCH, SHALL stall with inst_req high while inst_valid is low; on inst_valid high, IR <= inst_data, pc <= pc+1 mod 2^PC_W, and state goes to EXEC when op != 10, or LOADA when op == 10.
REQ-017 MOV (op 00), in EXEC: R[f1] <= R[f2], retire, then FETCH; flags unchanged.
REQ-018 LDI (op 01), in EXEC: R[f1] <= f2 zero-extended to DATA_W, retire, then FETCH; flags unchanged.
REQ-019 ALU (op 10) sequence: LOADA RA <= R0; ALU RC <= f(RA, R[f1]) with flags updated; WB R0 <= RC with retire, then FETCH.
REQ-020 ALU function select f2: 000 ADD, 001 SUB (RA-B), 010 AND, 011 OR, 100 XOR, 101 NOT B, 110 SHL B by 1, 111 SHR B by 1 (logical); B = R[f1].
REQ-021 zero_flag SHALL be set iff the DATA_W-bit result is 0; all arithmetic SHALL wrap modulo 2^DATA_W.
REQ-022 carry_flag: ADD = carry out; SUB = borrow (RA < B unsigned); SHL = B[DATA_W-1]; SHR = B[0]; AND/OR/XOR/NOT = 0.
REQ-023 Control (op 11), in EXEC, decoded on f1: 000 NOP; 001 HALT (go to HALT); 010 JZ (if zero_flag, pc <= R[f2][PC_W-1:0], zero-extended when PC_W > DATA_W); 011 JMP (unconditional, same target rule); 1xx NOP.
REQ-024 Every control instruction SHALL pulse retire in its EXEC cycle.
REQ-025 HALT SHALL hold all state, keep inst_req low and halted high, and leave HALT only on rst.
REQ-026 Latency in cycles from inst_valid acceptance to retire SHALL be: MOV/LDI/control 1; ALU 3.
REQ-027 A write to R0 in WB SHALL be visible on r0_out in the following cycle.
REQ-028 inst_data SHALL be ignored in every state other than FETCH.

Reset
REQ-029 While rst is high: pc = 0, R0..R7 = 0, RA = RC = 0, IR = 0, flags = 0, state = FETCH.
REQ-030 Output values during reset SHALL be: inst_req = 1, inst_addr = 0, halted = 0, retire = 0, r0_out = 0.
REQ-031 rst asserted mid-instruction SHALL abort the instruction with no register write; after release, fetch SHALL resume at address 0.

Verification
REQ-032 Reset, then feed LDI R1,5 (0x4D) at addr 0 -> retire 1 cycle after acceptance, R1 = 5, inst_addr = 1.
REQ-033 LDI R0,7; LDI R1,3; ADD R1 (0x88) -> r0_out = 10, zero = 0, carry = 0, retire 3 cycles after acceptance.
REQ-034 DATA_W = 8: R0 = 0, R1 = 1, SUB R1 -> r0_out = 0xFF, carry = 1; then LDI R0,1; ADD R1 after R1 = 0xFF (built via NOT) -> r0_out = 0, zero = 1, carry = 1.
REQ-035 Hold inst_valid low for 5 cycles in FETCH -> inst_req stays high, pc unchanged, no retire.
REQ-036 zero = 1, R2 = 0x10, JZ R2 (0xD2) -> next inst_addr = 0x10; same with zero = 0 -> inst_addr = pc+1.
REQ-037 HALT (0xC8) -> halted = 1, inst_req = 0 indefinitely; rst pulse mid-ALU sequence -> R0 unchanged from reset value 0, inst_addr = 0.

Source files
------------

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: 8-bit instruction fetch, MOV/LDI/ALU/control execute,
// with a three-step ALU path (load RA, compute RC + flags, write back R0).
module cpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req,
  output logic [PC_W-1:0]   inst_addr,
  input  logic              inst_valid,
  input  logic [7:0]        inst_data,
  output logic              halted,
  output logic              retire,
  output logic [DATA_W-1:0] r0_out,
  output logic              zero_flag,
  output logic              carry_flag
);

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StLoadA,
    StAlu,
    StWb,
    StHalt
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] ra_q, rc_q;
  logic [PC_W-1:0]   pc_q;
  logic [7:0]        ir_q;
  logic              zf_q, cf_q;

  logic [1:0] op;
  logic [2:0] f1, f2;
  assign op = ir_q[7:6];
  assign f1 = ir_q[5:3];
  assign f2 = ir_q[2:0];

  logic [PC_W-1:0] jmp_tgt;
  if (PC_W <= DATA_W) begin : g_tgt_slice
    assign jmp_tgt = regs_q[f2][PC_W-1:0];
  end else begin : g_tgt_ext
    assign jmp_tgt = {{(PC_W - DATA_W){1'b0}}, regs_q[f2]};
  end

  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_carry;

  always_comb begin
    alu_b     = regs_q[f1];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (f2)
      3'b000: {alu_carry, alu_res} = {1'b0, ra_q} + {1'b0, alu_b};
      // Extended subtraction: MSB of the result is the unsigned borrow.
      3'b001: {alu_carry, alu_res} = {1'b0, ra_q} - {1'b0, alu_b};
      3'b010: alu_res = ra_q & alu_b;
      3'b011: alu_res = ra_q | alu_b;
      3'b100: alu_res = ra_q ^ alu_b;
      3'b101: alu_res = ~alu_b;
      3'b110: begin
        alu_res   = {alu_b[DATA_W-2:0], 1'b0};
        alu_carry = alu_b[DATA_W-1];
      end
      default: begin
        alu_res   = {1'b0, alu_b[DATA_W-1:1]};
        alu_carry = alu_b[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    inst_req = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      StFetch: begin
        inst_req = 1'b1;
        if (inst_valid) state_d = (inst_data[7:6] == 2'b10) ? StLoadA : StExec;
      end
      StExec: begin
        retire  = 1'b1;
        state_d = (op == 2'b11 && f1 == 3'b001) ? StHalt : StFetch;
      end
      StLoadA: state_d = StAlu;
      StAlu:   state_d = StWb;
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      ra_q <= '0;
      rc_q <= '0;
      pc_q <= '0;
      ir_q <= '0;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (inst_valid) begin
            ir_q <= inst_data;
            pc_q <= pc_q + {{(PC_W - 1){1'b0}}, 1'b1};
          end
        end
        StExec: begin
          case (op)
            2'b00: regs_q[f1] <= regs_q[f2];
            2'b01: regs_q[f1] <= {{(DATA_W - 3){1'b0}}, f2};
            2'b11: begin
              if ((f1 == 3'b010 && zf_q) || f1 == 3'b011) pc_q <= jmp_tgt;
            end
            default: ;
          endcase
        end
        StLoadA: ra_q <= regs_q[0];
        StAlu: begin
          rc_q <= alu_res;
          zf_q <= (alu_res == '0);
          cf_q <= alu_carry;
        end
        StWb: regs_q[0] <= rc_q;
        default: ;
      endcase
    end
  end

  assign inst_addr  = pc_q;
  assign r0_out     = regs_q[0];
  assign zero_flag  = zf_q;
  assign carry_flag = cf_q;

endmodule

// File: tb/tb_cpu_core.sv
// Randomized self-checking bench for cpu_core: the bench acts as instruction memory and
// compares each retired instruction against an architectural model of the register file.
module tb_cpu_core;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam longint DMOD = longint'(1) << DW;
  localparam longint PMOD = longint'(1) << PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [PW-1:0] inst_addr;
  logic          inst_valid;
  logic [7:0]    inst_data;
  logic          halted;
  logic          retire;
  logic [DW-1:0] r0_out;
  logic          zero_flag;
  logic          carry_flag;

  cpu_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .halted     (halted),
    .retire     (retire),
    .r0_out     (r0_out),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural model: plain integer state, one call per instruction.
  longint m_r[8];
  longint m_pc;
  bit     m_z, m_c, m_halt;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
  endfunction

  // Returns the expected acceptance-to-retire latency.
  function automatic int m_exec(input logic [7:0] ins);
    int op, f1, f2;
    longint a, b, res;
    bit c;
    op = int'(ins[7:6]); f1 = int'(ins[5:3]); f2 = int'(ins[2:0]);
    m_pc = (m_pc + 1) % PMOD;
    case (op)
      0: m_r[f1] = m_r[f2];
      1: m_r[f1] = f2;
      2: begin
        a = m_r[0]; b = m_r[f1]; c = 0; res = 0;
        case (f2)
          0: begin res = (a + b) % DMOD; c = (a + b) >= DMOD; end
          1: begin res = (a - b + DMOD) % DMOD; c = a < b; end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: res = (DMOD - 1) - b;
          6: begin res = (b * 2) % DMOD; c = b >= DMOD / 2; end
          default: begin res = b / 2; c = (b % 2) == 1; end
        endcase
        m_r[0] = res; m_z = (res == 0); m_c = c;
        return 3;
      end
      default: begin
        if (f1 == 1) m_halt = 1;
        else if ((f1 == 2 && m_z) || f1 == 3) m_pc = m_r[f2] % PMOD;
      end
    endcase
    return 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.inst_req", inst_req, 1);
    check("rst.inst_addr", inst_addr, 0);
    check("rst.halted", halted, 0);
    check("rst.retire", retire, 0);
    check("rst.r0", r0_out, 0);
    check("rst.flags", {zero_flag, carry_flag}, 0);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  // Called at a negedge with the core in FETCH; returns at the negedge after retire.
  task automatic issue(input logic [7:0] ins, input int stall, input string tag);
    int lat, exp_lat;
    check({tag, ".req"}, inst_req, 1);
    check({tag, ".addr"}, inst_addr, m_pc);
    for (int i = 0; i < stall; i++) begin
      inst_valid = 1'b0;
      inst_data  = 8'($urandom);
      @(negedge clk);
    end
    inst_valid = 1'b1;
    inst_data  = ins;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    inst_data  = 8'($urandom);
    lat = 1;
    while (!retire && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = m_exec(ins);
    check({tag, ".latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, ".r0"}, r0_out, m_r[0]);
    check({tag, ".zero"}, zero_flag, m_z);
    check({tag, ".carry"}, carry_flag, m_c);
    check({tag, ".halted"}, halted, m_halt);
    if (!m_halt) check({tag, ".next_addr"}, inst_addr, m_pc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ins;
    logic [DW-1:0] r0_hold;
    rst = 1'b1;
    inst_valid = 1'b0;
    inst_data = 8'h00;
    m_reset();
    do_reset();

    // Single LDI, then the R0 = 7 + 3 ALU sequence.
    issue(8'h4D, 0, "ldi_r1_5");
    check("ldi.addr1", inst_addr, 1);
    issue(8'h47, 1, "ldi_r0_7");
    issue(8'h4B, 0, "ldi_r1_3");
    issue(8'h88, 2, "add_r1");
    check("add.r0_is_10", r0_out, 10);

    // Borrow on 0 - 1, then wrap to zero on 1 + 0xFF.
    issue(8'h40, 0, "ldi_r0_0");
    issue(8'h49, 0, "ldi_r1_1");
    issue(8'h89, 0, "sub_r1");
    check("sub.r0_ff", r0_out, 8'hFF);
    check("sub.borrow", carry_flag, 1);
    issue(8'h50, 0, "ldi_r2_0");
    issue(8'h95, 0, "not_r2");
    issue(8'h08, 0, "mov_r1_r0");
    issue(8'h41, 0, "ldi_r0_1");
    issue(8'h88, 0, "add_wrap");
    check("wrap.r0", r0_out, 0);
    check("wrap.zc", {zero_flag, carry_flag}, 2'b11);

    // Fetch stall: five idle cycles with no retire and a frozen address.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.req", inst_req, 1);
      check("stall.addr", inst_addr, m_pc);
      check("stall.retire", retire, 0);
    end

    // Build R2 = 0x10 by shifts, then JZ not taken and taken.
    issue(8'h52, 0, "ldi_r2_2");
    for (int i = 0; i < 3; i++) begin
      issue(8'h96, 0, "shl_r2");
      issue(8'h10, 0, "mov_r2_r0");
    end
    issue(8'hD2, 0, "jz_not_taken");
    issue(8'h60, 0, "ldi_r4_0");
    issue(8'hA2, 0, "and_r4");
    issue(8'hD2, 0, "jz_taken");
    check("jz.target", inst_addr, 8'h10);

    // Random instruction stream (HALT excluded).
    for (int n = 0; n < 400; n++) begin
      ins = 8'($urandom);
      if (ins[7:6] == 2'b11 && ins[5:3] == 3'b001) ins[5:3] = 3'b011;
      issue(ins, int'($urandom_range(0, 2)), "rand");
    end

    // HALT holds everything regardless of memory activity.
    issue(8'hC8, 0, "halt");
    r0_hold = r0_out;
    for (int i = 0; i < 6; i++) begin
      inst_valid = 1'($urandom);
      inst_data  = 8'($urandom);
      @(negedge clk);
      check("halt.halted", halted, 1);
      check("halt.req", inst_req, 0);
      check("halt.retire", retire, 0);
      check("halt.r0", r0_out, r0_hold);
    end
    do_reset();

    // Reset in the middle of an ALU sequence aborts it.
    issue(8'h4B, 0, "pre_abort_ldi");
    inst_valid = 1'b1;
    inst_data  = 8'h88;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.r0", r0_out, 0);
    check("abort.retire", retire, 0);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    check("abort.addr", inst_addr, 0);
    check("abort.req", inst_req, 1);
    issue(8'h88, 0, "post_abort_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
